// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// clock-divider helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    // Clocks per bit, truncated.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bus interface between uart_rx and the CPU bus decoder.
//
// Handshake: recvValid=1 means recvData holds an unconsumed byte and
// recvData stays stable while recvValid=1. The consumer pulses recvAck to
// take the byte; recvAck has no effect in a cycle where recvValid=0.
// frameError and overrun are single-cycle status pulses from the receiver.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] recvData;
    logic                      recvValid;
    logic                      recvAck;
    logic                      frameError;
    logic                      overrun;

    modport master (
        output recvData,
        output recvValid,
        output frameError,
        output overrun,
        input  recvAck
    );

    modport slave (
        input  recvData,
        input  recvValid,
        input  frameError,
        input  overrun,
        output recvAck
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO used when UART_RX_FIFO_EN is defined. A push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous receiver, LSB first, mid-bit sampling.
// Build option UART_RX_FIFO_EN: replaces the single holding register with a
// 4-entry uart_rx_fifo (overrun then only when the FIFO is full).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115200
) (
    input  logic           clk12MHz,
    input  logic           resetn,
    input  logic           rx,
    uart_rx_if.master      bus,
    output uart_rx_state_t dbg_state
);
    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

    logic rx_s1, rx_s2, rx_prev;

    uart_rx_state_t            state, state_next;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;

    logic cnt_zero;
    logic load_half, load_full, shift_bit, deliver, frame_err;

    assign cnt_zero  = (cnt == '0);
    assign dbg_state = state;

    // Two-flop synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // State register.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next state and datapath controls.
    always_comb begin
        state_next = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        shift_bit  = 1'b0;
        deliver    = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s2) begin
                    state_next = START;
                    load_half  = 1'b1;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (!rx_s2) begin
                        state_next = DATA;
                        load_full  = 1'b1;
                    end else begin
                        state_next = IDLE;   // glitch, not a real start bit
                    end
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_bit = 1'b1;
                    load_full = 1'b1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                    if (rx_s2) deliver   = 1'b1;
                    else       frame_err = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timer, bit index and shift register.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (load_half)       cnt <= CNT_HALF;
            else if (load_full)  cnt <= CNT_FULL;
            else if (!cnt_zero)  cnt <= cnt - CW'(1);

            if (state == START)  bit_idx <= '0;
            else if (shift_bit)  bit_idx <= bit_idx + 3'd1;

            if (shift_bit) shreg <= {rx_s2, shreg[UART_DATA_BITS-1:1]};
        end
    end

    // Framing error pulse, aligned with the cycle recvValid would rise.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) bus.frameError <= 1'b0;
        else         bus.frameError <= frame_err;
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_empty, fifo_full;

    uart_rx_fifo #(
        .DEPTH (4),
        .W     (UART_DATA_BITS)
    ) u_fifo (
        .clk    (clk12MHz),
        .resetn (resetn),
        .push   (deliver),
        .din    (shreg),
        .pop    (bus.recvAck),
        .dout   (bus.recvData),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign bus.recvValid = !fifo_empty;

    // Overrun only when a byte completes into a full FIFO with no pop.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) bus.overrun <= 1'b0;
        else         bus.overrun <= deliver && fifo_full && !bus.recvAck;
    end
`else
    // Single holding register with valid/ack handshake.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            bus.recvData  <= '0;
            bus.recvValid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.overrun <= 1'b0;
            if (deliver) begin
                if (!bus.recvValid || bus.recvAck) begin
                    bus.recvData  <= shreg;
                    bus.recvValid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;   // keep the old byte, drop the new
                end
            end else if (bus.recvAck && bus.recvValid) begin
                bus.recvValid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first. It is the receive-side companion of the existing `uart` transmitter core, and the two are meant to share one line pair. It sits beside that transmitter on the CPU memory/IO bus: the bus decoder reads `recvData` and `recvValid` and pulses `recvAck` to consume a byte. A 2-flop input synchronizer, a mid-bit sampling state machine and a holding stage with a valid/ack handshake convert the `rx` pin into bytes.

## Interface
- `CLK_HZ`, default 12_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `DIV = CLK_HZ / BAUD`, truncated (104 at defaults). `DIV` must be ≥ 4.
- `clk12MHz`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk12MHz`, idle high.
- `recvData`  out  8  received byte; stable while `recvValid`=1.
- `recvValid`  out  1  a byte is available.
- `recvAck`  in  1  consume the byte; only effective in a cycle where `recvValid`=1.
- `frameError`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer:** `rx` passes through 2 flops. Both flops reset to 1. A third flop holds the previous synchronized value, used for falling-edge detection.
- **State machine:** states IDLE, START, DATA, STOP. One counter `cnt` is sized to hold `DIV`-1, plus a 3-bit bit index.
- **IDLE:** on a synchronized falling edge (previous=1, current=0), load `cnt`=`DIV/2`-1 and go to START.
- **START:** when `cnt` reaches 0, sample the line.
  - Low: load `cnt`=`DIV`-1, set bit index to 0, go to DATA.
  - High: the edge was a glitch; return to IDLE with no output.
- **DATA:** each time `cnt` reaches 0, shift the sampled bit into the shift register MSB, so bit 0 ends up LSB.
  - Reload `cnt`=`DIV`-1.
  - After bit index 7, go to STOP.
- **STOP:** when `cnt` reaches 0, sample the line.
  - High: deliver the byte to the holding stage.
  - Low: pulse `frameError` and discard the byte.
  - In either case go to IDLE. A held-low line (break) creates no new frame until it returns high and falls again.
- **Holding stage (single register):**
  - Deliver while `recvValid`=0: load `recvData` and set `recvValid`.
  - `recvAck` while `recvValid`=1: clear `recvValid`.
  - Deliver and ack in the same cycle: load the new byte and keep `recvValid`=1; no overrun.
  - Deliver while `recvValid`=1 with no ack: drop the new byte, keep the old one, and pulse `overrun`.
- **Reset:** asserting `resetn` mid-frame returns to IDLE immediately and clears all state. Reset values: `recvData`=0x00, `recvValid`=0, `frameError`=0, `overrun`=0.

## Timing
- The start edge is detected 3 cycles after `rx` falls: 2 synchronizer flops plus the edge flop.
- Sample points, measured from edge detection:
  - start bit: `DIV/2` cycles;
  - data bit k: `DIV/2 + (k+1)·DIV` cycles;
  - stop bit: `DIV/2 + 9·DIV` cycles.
- `recvValid` rises 1 cycle after the stop sample, about 9.5 bit times after the `rx` falling edge.
- `frameError` and `overrun` are high for exactly 1 cycle, in the same cycle `recvValid` would have risen.
- Back-to-back frames are supported: IDLE is re-entered 0.5 bit before the stop bit ends.

## Configuration
- Macro: `UART_RX_FIFO_EN`.
- **Defined:** the holding register is replaced by a 4-entry FIFO.
  - `recvData` shows the FIFO head; `recvValid` means not empty.
  - `recvAck` pops the head.
  - `overrun` pulses only when a byte completes while the FIFO holds 4 entries with no pop in that cycle.
  - A simultaneous push and pop on a full FIFO keeps the count at 4.
- **Undefined:** single holding register exactly as described in Operation.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, STOP);
  - the `UART_DATA_BITS`=8 constant;
  - the `uart_div(CLK_HZ, BAUD)` function, also usable by the transmitter.
- One sub-module, `uart_rx_fifo`, depth parameter default 4, handles the `UART_RX_FIFO_EN` build only. The non-FIFO build is inline.

## Test plan
- **Single byte:** send 0xA5 at 115200 baud (104 clocks/bit) → `recvValid` rises about 991 cycles after the `rx` fall with `recvData`=0xA5. After a `recvAck` pulse, `recvValid`=0.
- **Glitch:** hold `rx` low for 30 cycles, then high → no `recvValid`, no `frameError`, state back in IDLE.
- **Framing error:** send 0x3C with the stop bit low → `frameError` pulses 1 cycle, `recvValid` stays 0. Drive the line low for 2000 more cycles → no new frame until a high-then-fall.
- **Overrun, no FIFO:** send 0x11 then 0x22 back-to-back without ack → `recvData`=0x11, one `overrun` pulse. Send 0x33 with ack asserted in the delivery cycle → `recvData`=0x33, no `overrun`.
- **FIFO build:** send 0x01–0x05 without ack → pops return 0x01–0x04, with one `overrun` on the 5th byte.
- **Reset mid-frame:** assert `resetn`=0 during data bit 3, then release → all outputs 0. The next frame 0x5A is received correctly.
